// File: rtl/mc_pipeline_ctrl_pkg.sv
// Microcode word layout, control-bit decode helpers and the per-stage pipeline register type.
// Bits 24:7 are datapath fields this controller passes through without interpreting.
package microcode;
    localparam int WIDTH      = 25;
    localparam int REG_W      = 5;
    localparam int NUM_STAGES = 4;

    localparam int B_REG_WE   = 0;
    localparam int B_RS1_DEP  = 1;
    localparam int B_RS2_DEP  = 2;
    localparam int B_MEM_USE  = 3;
    localparam int B_MEM_WE   = 4;
    localparam int B_ALU_PC   = 5;
    localparam int B_JMP_CMP  = 6;

    typedef logic [WIDTH-1:0] mc_t;

    typedef struct packed {
        logic             valid;
        mc_t              mc;
        logic [REG_W-1:0] rd;
    } stage_t;

    function automatic logic reg_we(input mc_t mc);
        return mc[B_REG_WE];
    endfunction

    function automatic logic check_rs1_dep(input mc_t mc);
        return mc[B_RS1_DEP];
    endfunction

    function automatic logic check_rs2_dep(input mc_t mc);
        return mc[B_RS2_DEP];
    endfunction

    function automatic logic mem_in_use(input mc_t mc);
        return mc[B_MEM_USE];
    endfunction

    function automatic logic mem_we(input mc_t mc);
        return mc[B_MEM_WE];
    endfunction

    function automatic logic alu_out_over_pc(input mc_t mc);
        return mc[B_ALU_PC];
    endfunction

    function automatic logic jump_if_cmp(input mc_t mc);
        return mc[B_JMP_CMP];
    endfunction

    // Unconditional jumps take the ALU result; conditional ones need the S2 comparator.
    function automatic logic mc_is_jump(input mc_t mc, input logic cmp);
        return alu_out_over_pc(mc) | (jump_if_cmp(mc) & cmp);
    endfunction
endpackage

// File: rtl/mc_pipeline_ctrl_hazard_detect.sv
// RAW hazard check of the S0 sources against every in-flight writer in S1..S3.
// No forwarding exists, so a match in any later stage (S3 included) must stall.
module mc_hazard_detect
    import microcode::*;
#(
    parameter int REG_ADDR_W = REG_W
) (
    input  logic                  i_s0_valid,
    input  mc_t                   i_s0_mc,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  stage_t [2:0]          i_stg,
    output logic                  o_hazard
);
    logic w_hit1;
    logic w_hit2;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (i_stg[k].valid && reg_we(i_stg[k].mc)) begin
                if (i_stg[k].rd == i_rs1) w_hit1 = 1'b1;
                if (i_stg[k].rd == i_rs2) w_hit2 = 1'b1;
            end
        end
    end

    // x0 is hard-wired zero, so writes to it never create a dependency.
    assign o_hazard = i_s0_valid &
                      ((check_rs1_dep(i_s0_mc) & (i_rs1 != '0) & w_hit1) |
                       (check_rs2_dep(i_s0_mc) & (i_rs2 != '0) & w_hit2));
endmodule

// File: rtl/mc_pipeline_ctrl.sv
// Four-stage microcode pipeline controller: issue stall on RAW hazards, wrong-path squash on
// taken S2 jumps, and single memory port arbitration with S1 data access over fetch.
module mc_pipeline_ctrl
    import microcode::*;
#(
    parameter int MC_WIDTH   = WIDTH,
    parameter int REG_ADDR_W = REG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [MC_WIDTH-1:0]   dec_mc,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  cmp_result,
    output logic [MC_WIDTH-1:0]   s0_mc,
    output logic [MC_WIDTH-1:0]   s1_mc,
    output logic [MC_WIDTH-1:0]   s2_mc,
    output logic [MC_WIDTH-1:0]   s3_mc,
    output logic                  s0_valid,
    output logic                  s1_valid,
    output logic                  s2_valid,
    output logic                  s3_valid,
    output logic [REG_ADDR_W-1:0] s3_rd,
    output logic                  redirect,
    output logic                  fetch_grant
);
    stage_t [NUM_STAGES-1:0] r_stg;
    logic [REG_ADDR_W-1:0]   r_s0_rs1;
    logic [REG_ADDR_W-1:0]   r_s0_rs2;

    logic w_hazard;
    logic w_redirect;
    logic w_s0_adv;
    logic w_take;

    mc_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .i_s0_valid (r_stg[0].valid),
        .i_s0_mc    (r_stg[0].mc),
        .i_rs1      (r_s0_rs1),
        .i_rs2      (r_s0_rs2),
        .i_stg      (r_stg[3:1]),
        .o_hazard   (w_hazard)
    );

    assign w_redirect = r_stg[2].valid & mc_is_jump(r_stg[2].mc, cmp_result);
    assign w_s0_adv   = r_stg[0].valid & ~w_hazard & ~w_redirect;
    assign w_take     = dec_valid & dec_ready;

    assign dec_ready   = ~rst & ~w_redirect & (~r_stg[0].valid | w_s0_adv);
    assign redirect    = w_redirect;
    assign fetch_grant = ~(r_stg[1].valid & mem_in_use(r_stg[1].mc));

    // Invalid stages present an all-zero word so no write enable leaks downstream.
    assign s0_valid = r_stg[0].valid;
    assign s1_valid = r_stg[1].valid;
    assign s2_valid = r_stg[2].valid;
    assign s3_valid = r_stg[3].valid;
    assign s0_mc    = r_stg[0].valid ? r_stg[0].mc : '0;
    assign s1_mc    = r_stg[1].valid ? r_stg[1].mc : '0;
    assign s2_mc    = r_stg[2].valid ? r_stg[2].mc : '0;
    assign s3_mc    = r_stg[3].valid ? r_stg[3].mc : '0;
    assign s3_rd    = r_stg[3].rd;

    // Squashed and bubbled entries are written as all-zero, not just valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg    <= '0;
            r_s0_rs1 <= '0;
            r_s0_rs2 <= '0;
        end else begin
            r_stg[3] <= r_stg[2];
            r_stg[2] <= w_redirect ? '0 : r_stg[1];
            r_stg[1] <= w_s0_adv ? r_stg[0] : '0;
            if (w_take) begin
                r_stg[0] <= '{valid: 1'b1, mc: dec_mc, rd: dec_rd};
                r_s0_rs1 <= dec_rs1;
                r_s0_rs2 <= dec_rs2;
            end else if (w_s0_adv || w_redirect) begin
                r_stg[0] <= '0;
                r_s0_rs1 <= '0;
                r_s0_rs2 <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mc_pipeline_ctrl.sv
// Randomized and directed bench for mc_pipeline_ctrl against a cycle-level reference model
// built from the stage/hazard/squash rules over plain arrays.
module tb_mc_pipeline_ctrl;
    import microcode::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready, cmp_result;
    logic [24:0] dec_mc;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [24:0] s0_mc, s1_mc, s2_mc, s3_mc;
    logic        s0_valid, s1_valid, s2_valid, s3_valid;
    logic [4:0]  s3_rd;
    logic        redirect, fetch_grant;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0..3 = S0..S3
    logic        m_v  [4];
    logic [24:0] m_mc [4];
    logic [4:0]  m_rd [4];
    logic [4:0]  m_rs1, m_rs2;

    always #5 clk = ~clk;

    mc_pipeline_ctrl dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_mc(dec_mc), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .cmp_result(cmp_result),
        .s0_mc(s0_mc), .s1_mc(s1_mc), .s2_mc(s2_mc), .s3_mc(s3_mc),
        .s0_valid(s0_valid), .s1_valid(s1_valid), .s2_valid(s2_valid), .s3_valid(s3_valid),
        .s3_rd(s3_rd), .redirect(redirect), .fetch_grant(fetch_grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_v[k] = 1'b0; m_mc[k] = '0; m_rd[k] = '0;
        end
        m_rs1 = '0; m_rs2 = '0;
    endtask

    function automatic logic [24:0] rnd_mc();
        logic [24:0] w;
        w = 25'($urandom);
        w[B_REG_WE]  = ($urandom_range(0, 9) < 7);
        w[B_RS1_DEP] = $urandom_range(0, 1);
        w[B_RS2_DEP] = $urandom_range(0, 1);
        w[B_MEM_USE] = ($urandom_range(0, 9) < 3);
        w[B_MEM_WE]  = w[B_MEM_USE] & $urandom_range(0, 1);
        w[B_ALU_PC]  = ($urandom_range(0, 19) == 0);
        w[B_JMP_CMP] = ($urandom_range(0, 19) < 3);
        return w;
    endfunction

    function automatic logic [24:0] plain_mc(input logic [6:0] ctl);
        logic [24:0] w;
        w = 25'($urandom);
        w[6:0] = ctl;
        return w;
    endfunction

    // One clock: drive at negedge, compare settled outputs with the model, advance model.
    task automatic step(input logic dv, input logic [24:0] mc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic cmp,
                        output logic acc, output logic obs_redir);
        logic e_redir, e_hz, e_adv, e_ready;
        @(negedge clk);
        dec_valid = dv; dec_mc = mc; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2; cmp_result = cmp;
        #1;
        e_redir = m_v[2] && (m_mc[2][B_ALU_PC] || (m_mc[2][B_JMP_CMP] && cmp));
        e_hz = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (m_v[k] && m_mc[k][B_REG_WE]) begin
                if (m_mc[0][B_RS1_DEP] && m_rs1 != 0 && m_rd[k] == m_rs1) e_hz = 1'b1;
                if (m_mc[0][B_RS2_DEP] && m_rs2 != 0 && m_rd[k] == m_rs2) e_hz = 1'b1;
            end
        end
        e_hz    = e_hz && m_v[0];
        e_adv   = m_v[0] && !e_hz && !e_redir;
        e_ready = !e_redir && (!m_v[0] || e_adv);

        chk("dec_ready",   dec_ready,   e_ready);
        chk("redirect",    redirect,    e_redir);
        chk("fetch_grant", fetch_grant, !(m_v[1] && m_mc[1][B_MEM_USE]));
        chk("s0_valid", s0_valid, m_v[0]);
        chk("s1_valid", s1_valid, m_v[1]);
        chk("s2_valid", s2_valid, m_v[2]);
        chk("s3_valid", s3_valid, m_v[3]);
        chk("s0_mc", s0_mc, m_v[0] ? m_mc[0] : 25'd0);
        chk("s1_mc", s1_mc, m_v[1] ? m_mc[1] : 25'd0);
        chk("s2_mc", s2_mc, m_v[2] ? m_mc[2] : 25'd0);
        chk("s3_mc", s3_mc, m_v[3] ? m_mc[3] : 25'd0);
        chk("s3_rd", s3_rd, m_v[3] ? m_rd[3] : 5'd0);
        acc       = dv && e_ready;
        obs_redir = redirect;

        m_v[3] = m_v[2]; m_mc[3] = m_mc[2]; m_rd[3] = m_rd[2];
        if (e_redir) begin
            m_v[2] = 1'b0; m_mc[2] = '0; m_rd[2] = '0;
        end else begin
            m_v[2] = m_v[1]; m_mc[2] = m_mc[1]; m_rd[2] = m_rd[1];
        end
        if (e_adv) begin
            m_v[1] = m_v[0]; m_mc[1] = m_mc[0]; m_rd[1] = m_rd[0];
        end else begin
            m_v[1] = 1'b0; m_mc[1] = '0; m_rd[1] = '0;
        end
        if (acc) begin
            m_v[0] = 1'b1; m_mc[0] = mc; m_rd[0] = rd; m_rs1 = rs1; m_rs2 = rs2;
        end else if (e_adv || e_redir) begin
            m_v[0] = 1'b0; m_mc[0] = '0; m_rd[0] = '0; m_rs1 = '0; m_rs2 = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        dec_valid = 1'b0;
        #1;
        chk("rst_s0_valid", s0_valid, 1'b0);
        chk("rst_s1_valid", s1_valid, 1'b0);
        chk("rst_s2_valid", s2_valid, 1'b0);
        chk("rst_s3_valid", s3_valid, 1'b0);
        chk("rst_grant",    fetch_grant, 1'b1);
        chk("rst_redirect", redirect, 1'b0);
        chk("rst_ready",    dec_ready, 1'b0);
        chk("rst_s3_mc",    s3_mc, 25'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present producer, consumer, then a filler; count how often the filler is refused.
    task automatic pair_test(input string tag, input logic [24:0] p_mc, input logic [4:0] p_rd,
                             input logic [24:0] c_mc, input logic [4:0] c_rs1,
                             input int exp_refusals);
        logic acc, rd_o;
        int   refused;
        do_reset();
        step(1'b1, p_mc, p_rd, 5'd0, 5'd0, 1'b0, acc, rd_o);
        chk({tag, "_prod_acc"}, acc, 1'b1);
        step(1'b1, c_mc, 5'd6, c_rs1, 5'd0, 1'b0, acc, rd_o);
        chk({tag, "_cons_acc"}, acc, 1'b1);
        refused = 0;
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) begin
            step(1'b1, plain_mc(7'b0000001), 5'd7, 5'd0, 5'd0, 1'b0, acc, rd_o);
            if (!acc) refused++;
        end
        chk({tag, "_accepted"}, acc, 1'b1);
        chk({tag, "_stalls"}, refused, exp_refusals);
        for (int n = 0; n < 5; n++) step(1'b0, '0, '0, '0, '0, 1'b0, acc, rd_o);
    endtask

    task automatic branch_test(input logic cmp, input int exp_redirs);
        logic acc, rd_o;
        int   nred;
        do_reset();
        step(1'b1, plain_mc(7'b1000000), 5'd0, 5'd0, 5'd0, cmp, acc, rd_o);
        nred = 0;
        for (int n = 0; n < 8; n++) begin
            step(1'b1, plain_mc(7'b0000001), 5'd9, 5'd0, 5'd0, cmp, acc, rd_o);
            if (rd_o) nred++;
        end
        chk(cmp ? "beq_taken_redirs" : "beq_not_taken_redirs", nred, exp_redirs);
    endtask

    initial begin
        logic        acc, rd_o, have;
        logic [24:0] c_mc;
        logic [4:0]  c_rd, c_rs1, c_rs2;
        int          n_acc;

        rst = 1'b1; dec_valid = 1'b0; dec_mc = '0; dec_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; cmp_result = 1'b0;
        model_clear();
        #1;
        chk("por_ready", dec_ready, 1'b0);
        chk("por_grant", fetch_grant, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fill all four stages with independent ops, then reset mid-stream
        n_acc = 0;
        for (int n = 0; n < 12 && n_acc < 4; n++) begin
            step(1'b1, plain_mc(7'b0000001), 5'(n + 1), 5'd0, 5'd0, 1'b0, acc, rd_o);
            if (acc) n_acc++;
        end
        step(1'b0, '0, '0, '0, '0, 1'b0, acc, rd_o);
        do_reset();

        pair_test("raw_x5",   plain_mc(7'b0000001), 5'd5, plain_mc(7'b0000011), 5'd5, 3);
        pair_test("x0_src",   plain_mc(7'b0000001), 5'd0, plain_mc(7'b0000011), 5'd0, 0);
        pair_test("no_dep",   plain_mc(7'b0000001), 5'd5, plain_mc(7'b0000001), 5'd5, 0);
        pair_test("ld_raw",   plain_mc(7'b0001001), 5'd3, plain_mc(7'b0000011), 5'd3, 3);
        branch_test(1'b1, 1);
        branch_test(1'b0, 0);

        // Randomized traffic; small register range to provoke hazards
        do_reset();
        have = 1'b0;
        c_mc = '0; c_rd = '0; c_rs1 = '0; c_rs2 = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                have  = 1'b1;
                c_mc  = rnd_mc();
                c_rd  = 5'($urandom_range(0, 3));
                c_rs1 = 5'($urandom_range(0, 3));
                c_rs2 = 5'($urandom_range(0, 3));
            end
            step(have, c_mc, c_rd, c_rs1, c_rs2, 1'($urandom_range(0, 1)), acc, rd_o);
            if (acc || rd_o) have = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                have = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
